jtag_tap_ctrl: RTL
==================

Name: jtag_tap_ctrl

Overview:
IEEE 1149.1 TAP controller. A 16-state FSM advanced by TMS on each rising TCK edge. It decodes its state into the capture/shift/update strobes that drive the shared JTAG shift register and the IR/DR update logic. It sits directly upstream of the shift register and supplies its stateIsCapture*/stateIsShift* inputs.

Parameters:
None. State encoding is fixed: 4 bits, IEEE 1149.1 codes listed under Behaviour.

Ports:
i_tclk  input  1  TCK; the only clock, all state on its rising edge
i_trst_n  input  1  synchronous active-low reset, sampled on rising i_tclk
i_tms  input  1  test mode select, sampled on rising i_tclk
o_state  output  4  current state code
o_stateIsTestLogicReset  output  1  state == Test-Logic-Reset
o_stateIsRunTestIdle  output  1  state == Run-Test/Idle
o_stateIsCaptureDr  output  1  state == Capture-DR
o_stateIsCaptureIr  output  1  state == Capture-IR
o_stateIsShiftDr  output  1  state == Shift-DR
o_stateIsShiftIr  output  1  state == Shift-IR
o_stateIsUpdateDr  output  1  state == Update-DR
o_stateIsUpdateIr  output  1  state == Update-IR
o_selectIr  output  1  high in any IR-column state (Select-IR through Update-IR)
o_tdoEnable  output  1  high in Shift-DR or Shift-IR

Behaviour:
- Reset: synchronous. If i_trst_n == 0 at a rising i_tclk edge, state becomes Test-Logic-Reset regardless of i_tms.
  - After reset: o_state = 4'hF and o_stateIsTestLogicReset = 1.
  - All other o_stateIs* = 0, o_selectIr = 0, o_tdoEnable = 0.
- Reset mid-operation (any state, including Shift-*) forces Test-Logic-Reset on that edge. There is no partial completion and no Update-* pulse.
- Single state register. All outputs are combinational decodes of the registered state and carry no i_tms term. Latency: state changes 1 TCK after the sampling edge.
- Encodings:
  - Test-Logic-Reset F, Run-Test/Idle C
  - Select-DR 7, Capture-DR 6, Shift-DR 2, Exit1-DR 1, Pause-DR 3, Exit2-DR 0, Update-DR 5
  - Select-IR 4, Capture-IR E, Shift-IR A, Exit1-IR 9, Pause-IR B, Exit2-IR 8, Update-IR D
- Transitions, written as state: next on tms=0 / next on tms=1:
  - Test-Logic-Reset: Run-Test/Idle / Test-Logic-Reset
  - Run-Test/Idle: Run-Test/Idle / Select-DR
  - Select-DR: Capture-DR / Select-IR
  - Capture-DR: Shift-DR / Exit1-DR
  - Shift-DR: Shift-DR / Exit1-DR
  - Exit1-DR: Pause-DR / Update-DR
  - Pause-DR: Pause-DR / Exit2-DR
  - Exit2-DR: Shift-DR / Update-DR
  - Update-DR: Run-Test/Idle / Select-DR
  - Select-IR: Capture-IR / Test-Logic-Reset
  - IR column (Capture-IR through Update-IR): identical to the DR column
- Five consecutive tms=1 edges from any state reach Test-Logic-Reset. This is the required guarantee for software reset.
- Exactly one o_stateIs* is high in any state that has one. None is high in Select-*, Exit*, or Pause-*.
- Capture-* and Update-* each last exactly 1 TCK per visit. Shift-* lasts as long as tms stays 0.
- Pause-* keeps all strobes low so the downstream shift register holds its value.
- Unreachable codes cannot occur: all 16 codes are legal. The default branch goes to Test-Logic-Reset.

Test Plan:
- Reset: hold i_trst_n=0 for 2 edges with i_tms toggling -> o_state=F, o_stateIsTestLogicReset=1, all other outputs 0.
- DR scan: from F, apply tms=0,1,0,0,0,0,0,1,1,0.
  - State sequence: C,7,6,2,2,2,2,1,5,C.
  - o_stateIsCaptureDr high for 1 cycle, o_tdoEnable high for 4 cycles, o_stateIsUpdateDr high for 1 cycle.
- IR scan with pause: from C, apply tms=1,1,0,0,1,0,0,1,0,1,1.
  - State sequence: 7,4,E,A,9,B,B,8,A,9,D.
  - o_selectIr=1 from state 4 onward, o_tdoEnable=0 while in B.
- TMS reset: from Shift-DR (2), apply tms=1 x5 -> 1,5,7,4,F. Further tms=1 stays at F.
- Mid-scan hard reset: in Shift-IR, assert i_trst_n=0 for one edge with tms=0 -> next state F, no Update-IR strobe.
- Exit2 re-entry: Shift-DR -> Exit1 -> Pause -> Exit2 via tms=1,0,1, then tms=0 -> back to Shift-DR (2) with no Capture-DR strobe.

Source files
------------

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM stepped by TMS on rising TCK.
// Decodes the registered state into capture/shift/update strobes.
module jtag_tap_ctrl (
   input  logic       i_tclk,
   input  logic       i_trst_n,
   input  logic       i_tms,
   output logic [3:0] o_state,
   output logic       o_stateIsTestLogicReset,
   output logic       o_stateIsRunTestIdle,
   output logic       o_stateIsCaptureDr,
   output logic       o_stateIsCaptureIr,
   output logic       o_stateIsShiftDr,
   output logic       o_stateIsShiftIr,
   output logic       o_stateIsUpdateDr,
   output logic       o_stateIsUpdateIr,
   output logic       o_selectIr,
   output logic       o_tdoEnable
);

   typedef enum logic [3:0] {
      S_EXIT2_DR   = 4'h0,
      S_EXIT1_DR   = 4'h1,
      S_SHIFT_DR   = 4'h2,
      S_PAUSE_DR   = 4'h3,
      S_SELECT_IR  = 4'h4,
      S_UPDATE_DR  = 4'h5,
      S_CAPTURE_DR = 4'h6,
      S_SELECT_DR  = 4'h7,
      S_EXIT2_IR   = 4'h8,
      S_EXIT1_IR   = 4'h9,
      S_SHIFT_IR   = 4'hA,
      S_PAUSE_IR   = 4'hB,
      S_RTI        = 4'hC,
      S_UPDATE_IR  = 4'hD,
      S_CAPTURE_IR = 4'hE,
      S_TLR        = 4'hF
   } state_t;

   state_t r_state;
   state_t w_next;

   always_ff @(posedge i_tclk) begin
      if (!i_trst_n) r_state <= S_TLR;
      else           r_state <= w_next;
   end

   always_comb begin
      w_next = S_TLR;
      case (r_state)
         S_TLR:        w_next = i_tms ? S_TLR       : S_RTI;
         S_RTI:        w_next = i_tms ? S_SELECT_DR : S_RTI;
         S_SELECT_DR:  w_next = i_tms ? S_SELECT_IR : S_CAPTURE_DR;
         S_CAPTURE_DR: w_next = i_tms ? S_EXIT1_DR  : S_SHIFT_DR;
         S_SHIFT_DR:   w_next = i_tms ? S_EXIT1_DR  : S_SHIFT_DR;
         S_EXIT1_DR:   w_next = i_tms ? S_UPDATE_DR : S_PAUSE_DR;
         S_PAUSE_DR:   w_next = i_tms ? S_EXIT2_DR  : S_PAUSE_DR;
         S_EXIT2_DR:   w_next = i_tms ? S_UPDATE_DR : S_SHIFT_DR;
         S_UPDATE_DR:  w_next = i_tms ? S_SELECT_DR : S_RTI;
         S_SELECT_IR:  w_next = i_tms ? S_TLR       : S_CAPTURE_IR;
         S_CAPTURE_IR: w_next = i_tms ? S_EXIT1_IR  : S_SHIFT_IR;
         S_SHIFT_IR:   w_next = i_tms ? S_EXIT1_IR  : S_SHIFT_IR;
         S_EXIT1_IR:   w_next = i_tms ? S_UPDATE_IR : S_PAUSE_IR;
         S_PAUSE_IR:   w_next = i_tms ? S_EXIT2_IR  : S_PAUSE_IR;
         S_EXIT2_IR:   w_next = i_tms ? S_UPDATE_IR : S_SHIFT_IR;
         S_UPDATE_IR:  w_next = i_tms ? S_SELECT_DR : S_RTI;
         default:      w_next = S_TLR;
      endcase
   end

   // Pure decodes of the state register; no TMS term reaches an output.
   assign o_state                 = r_state;
   assign o_stateIsTestLogicReset = (r_state == S_TLR);
   assign o_stateIsRunTestIdle    = (r_state == S_RTI);
   assign o_stateIsCaptureDr      = (r_state == S_CAPTURE_DR);
   assign o_stateIsCaptureIr      = (r_state == S_CAPTURE_IR);
   assign o_stateIsShiftDr        = (r_state == S_SHIFT_DR);
   assign o_stateIsShiftIr        = (r_state == S_SHIFT_IR);
   assign o_stateIsUpdateDr       = (r_state == S_UPDATE_DR);
   assign o_stateIsUpdateIr       = (r_state == S_UPDATE_IR);
   assign o_tdoEnable             = o_stateIsShiftDr | o_stateIsShiftIr;

   // IR column codes all have bit 3 set except Select-IR (4) and the
   // two non-IR states TLR (F) and RTI (C) that also have bit 3 set.
   assign o_selectIr = (r_state == S_SELECT_IR) |
                       (r_state[3] &
                        (r_state != S_TLR) &
                        (r_state != S_RTI));

endmodule
